// File: rtl/ysyx_23060025_mem_stage_pkg.sv
// Shared bus widths, load/store and CSR encodings, and FSM state constants for the memory stage.
// Optional build macro MS_PERF_CNT_EN (see ysyx_23060025_mem_stage) adds performance counters.
package ysyx_23060025_mem_stage_pkg;

    localparam int ES_TO_MS_DATA_BUS    = 189;
    localparam int MS_TO_WB_DATA_BUS    = 151;
    localparam int MS_TO_DS_FORWARD_BUS = 87;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    localparam logic [2:0] CSR_CSRRW = 3'd1;
    localparam logic [2:0] CSR_CSRRS = 3'd2;
    localparam logic [2:0] CSR_ECALL = 3'd3;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_REQ  = 2'd1;
    localparam logic [1:0] MS_WAIT = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic        wd;
        logic [4:0]  wreg;
        logic [31:0] alu_result;
        logic        mem_en;
        logic [31:0] reg2;
        logic [2:0]  load_type;
        logic [1:0]  store_type;
        logic [31:0] csr_wdata;
        logic [2:0]  csr_flag;
        logic [11:0] csr_waddr;
        logic [31:0] csr_mcause;
        logic        ebreak;
        logic        fencei;
    } es_bus_t;

    // Encodings 6 and 7 are reserved and behave like "no load".
    function automatic logic valid_load(input logic [2:0] load_type);
        return (load_type >= LD_LB) && (load_type <= LD_LHU);
    endfunction

endpackage

// File: rtl/ysyx_23060025_load_ext.sv
// Combinational lane select and sign/zero extension of an aligned load word.
module ysyx_23060025_load_ext
    import ysyx_23060025_mem_stage_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = 8'(rdata >> {offset, 3'b000});
    assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
        result = rdata;
        case (load_type)
            LD_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            LD_LH:   result = {{16{half_lane[15]}}, half_lane};
            LD_LBU:  result = {24'd0, byte_lane};
            LD_LHU:  result = {16'd0, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060025_mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, runs one load/store on a req/gnt/rvalid port.
// Build macro MS_PERF_CNT_EN adds load/store/wait performance counter outputs.
module ysyx_23060025_mem_stage
    import ysyx_23060025_mem_stage_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic [ES_TO_MS_DATA_BUS-1:0]    es_to_ms_bus,
    input  logic                            es_to_lsu_valid_i,
    output logic                            lsu_allowin_o,
    output logic [MS_TO_WB_DATA_BUS-1:0]    ms_to_wb_bus,
    output logic                            ms_to_wb_valid_o,
    input  logic                            wb_allowin_i,
    output logic [MS_TO_DS_FORWARD_BUS-1:0] ms_to_ds_forward_bus,
    input  logic                            fencei_flush_sign_i,
    input  logic                            fencei_flush_valid_i,
    output logic                            data_req_o,
    output logic                            data_we_o,
    output logic [31:0]                     data_addr_o,
    output logic [3:0]                      data_wstrb_o,
    output logic [31:0]                     data_wdata_o,
    input  logic                            data_gnt_i,
    input  logic                            data_rvalid_i,
    input  logic [31:0]                     data_rdata_i
`ifdef MS_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_load_cnt_o,
    output logic [31:0]                     perf_store_cnt_o,
    output logic [31:0]                     perf_wait_cnt_o
`endif
);

    es_bus_t     in_bus, ms_bus;
    logic        ms_valid, done, orphan;
    logic [1:0]  state;
    logic [31:0] rdata_hold, load_result, final_result;
    logic        flush, is_load, is_store, mem_op, ready_go;
    logic        capture, in_is_mem, rsp_keep, leaving, csr_fwd;

    assign in_bus    = es_to_ms_bus;
    assign flush     = fencei_flush_sign_i & fencei_flush_valid_i;
    assign is_load   = ms_bus.mem_en & valid_load(ms_bus.load_type);
    assign is_store  = ms_bus.mem_en & ~is_load & (ms_bus.store_type != ST_NONE);
    assign mem_op    = is_load | is_store;
    assign ready_go  = mem_op ? done : 1'b1;
    assign in_is_mem = in_bus.mem_en & (valid_load(in_bus.load_type) | (in_bus.store_type != ST_NONE));

    assign lsu_allowin_o    = ~orphan & (~ms_valid | (ready_go & wb_allowin_i));
    assign ms_to_wb_valid_o = ms_valid & ready_go & ~flush;
    assign capture          = es_to_lsu_valid_i & lsu_allowin_o;
    assign leaving          = ms_to_wb_valid_o & wb_allowin_i;
    // A response counts only if its instruction is still alive.
    assign rsp_keep         = (state == MS_WAIT) & data_rvalid_i & ~orphan & ~flush;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            ms_bus   <= '0;
            ms_valid <= 1'b0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (lsu_allowin_o) begin
                ms_valid <= es_to_lsu_valid_i;
            end
            if (capture) begin
                ms_bus <= in_bus;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: the hold register is reset too, so the output buses read all-zero out of reset.
        if (reset) begin
            state      <= MS_IDLE;
            done       <= 1'b0;
            orphan     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            case (state)
                MS_IDLE: if (capture & in_is_mem & ~flush) state <= MS_REQ;
                MS_REQ: begin
                    if (data_gnt_i) begin
                        state  <= MS_WAIT;
                        orphan <= flush;
                    end else if (flush) begin
                        state <= MS_IDLE;
                    end
                end
                MS_WAIT: begin
                    if (data_rvalid_i) begin
                        state  <= MS_IDLE;
                        orphan <= 1'b0;
                    end else if (flush) begin
                        orphan <= 1'b1;
                    end
                end
                default: state <= MS_IDLE;
            endcase
            if (rsp_keep) begin
                rdata_hold <= data_rdata_i;
            end
            if (rsp_keep) begin
                done <= 1'b1;
            end else if (leaving | flush) begin
                done <= 1'b0;
            end
        end
    end

    assign data_req_o  = (state == MS_REQ);
    assign data_we_o   = is_store;
    assign data_addr_o = ms_bus.alu_result;

    always_comb begin
        data_wstrb_o = 4'b0000;
        data_wdata_o = '0;
        if (is_store) begin
            case (ms_bus.store_type)
                ST_SB: begin
                    data_wstrb_o = 4'b0001 << ms_bus.alu_result[1:0];
                    data_wdata_o = {4{ms_bus.reg2[7:0]}};
                end
                ST_SH: begin
                    data_wstrb_o = 4'b0011 << {ms_bus.alu_result[1], 1'b0};
                    data_wdata_o = {2{ms_bus.reg2[15:0]}};
                end
                default: begin
                    data_wstrb_o = 4'b1111;
                    data_wdata_o = ms_bus.reg2;
                end
            endcase
        end
    end

    ysyx_23060025_load_ext u_load_ext (
        .load_type (ms_bus.load_type),
        .offset    (ms_bus.alu_result[1:0]),
        .rdata     (rdata_hold),
        .result    (load_result)
    );

    assign final_result = is_load ? load_result : ms_bus.alu_result;
    assign csr_fwd      = ms_valid & ((ms_bus.csr_flag == CSR_CSRRW) | (ms_bus.csr_flag == CSR_CSRRS) |
                                      (ms_bus.csr_flag == CSR_ECALL));

    assign ms_to_wb_bus = {ms_bus.pc, ms_bus.wd, ms_bus.wreg, final_result,
                           ms_bus.csr_wdata, ms_bus.csr_flag, ms_bus.csr_waddr,
                           ms_bus.csr_mcause, ms_bus.ebreak, ms_bus.fencei};

    assign ms_to_ds_forward_bus = {ms_valid & is_load & ~done,
                                   ms_bus.wd & (ms_bus.wreg != 5'd0) & ms_valid,
                                   ms_bus.wreg, final_result, csr_fwd,
                                   ms_bus.csr_waddr, ms_bus.csr_wdata, ms_bus.csr_flag};

`ifdef MS_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_load_cnt_o  <= '0;
            perf_store_cnt_o <= '0;
            perf_wait_cnt_o  <= '0;
        end else begin
            if (rsp_keep & is_load)  perf_load_cnt_o  <= perf_load_cnt_o + 32'd1;
            if (rsp_keep & is_store) perf_store_cnt_o <= perf_store_cnt_o + 32'd1;
            if ((state == MS_REQ) | (state == MS_WAIT)) perf_wait_cnt_o <= perf_wait_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060025_mem_stage.sv
// Self-checking bench for ysyx_23060025_mem_stage: directed cases plus randomized instructions vs a model.
module tb_ysyx_23060025_mem_stage;
    import ysyx_23060025_mem_stage_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [188:0] es_to_ms_bus;
    logic         es_to_lsu_valid_i;
    logic         lsu_allowin_o;
    logic [150:0] ms_to_wb_bus;
    logic         ms_to_wb_valid_o;
    logic         wb_allowin_i;
    logic [86:0]  ms_to_ds_forward_bus;
    logic         fencei_flush_sign_i, fencei_flush_valid_i;
    logic         data_req_o, data_we_o;
    logic [31:0]  data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]   data_wstrb_o;
    logic         data_gnt_i, data_rvalid_i;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    ysyx_23060025_mem_stage dut (
        .clock                (clock),
        .reset                (reset),
        .es_to_ms_bus         (es_to_ms_bus),
        .es_to_lsu_valid_i    (es_to_lsu_valid_i),
        .lsu_allowin_o        (lsu_allowin_o),
        .ms_to_wb_bus         (ms_to_wb_bus),
        .ms_to_wb_valid_o     (ms_to_wb_valid_o),
        .wb_allowin_i         (wb_allowin_i),
        .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
        .fencei_flush_sign_i  (fencei_flush_sign_i),
        .fencei_flush_valid_i (fencei_flush_valid_i),
        .data_req_o           (data_req_o),
        .data_we_o            (data_we_o),
        .data_addr_o          (data_addr_o),
        .data_wstrb_o         (data_wstrb_o),
        .data_wdata_o         (data_wdata_o),
        .data_gnt_i           (data_gnt_i),
        .data_rvalid_i        (data_rvalid_i),
        .data_rdata_i         (data_rdata_i)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain arithmetic on the architectural load/store rules.
    function automatic logic [31:0] model_load(input int lt, input logic [31:0] addr, input logic [31:0] rdata);
        longint v;
        longint w;
        w = rdata;
        case (lt)
            1: begin v = (w >> (8 * (addr % 4))) % 256;       if (v >= 128)   v -= 256;   end
            2: begin v = (w >> (16 * ((addr / 2) % 2))) % 65536; if (v >= 32768) v -= 65536; end
            3: v = w;
            4: v = (w >> (8 * (addr % 4))) % 256;
            5: v = (w >> (16 * ((addr / 2) % 2))) % 65536;
            default: v = addr;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_wstrb(input int st, input logic [31:0] addr);
        case (st)
            1: return 4'(1 << (addr % 4));
            2: return ((addr / 2) % 2 == 1) ? 4'd12 : 4'd3;
            3: return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input int st, input logic [31:0] reg2);
        case (st)
            1: return (reg2 % 256) * 32'h0101_0101;
            2: return (reg2 % 65536) * 32'h0001_0001;
            default: return reg2;
        endcase
    endfunction

    function automatic es_bus_t mk_bus(input logic [31:0] alu, input bit mem_en, input logic [2:0] lt,
                                       input logic [1:0] st, input logic [31:0] reg2);
        es_bus_t b;
        b            = '0;
        b.pc         = $urandom();
        b.wd         = 1'($urandom_range(0, 1));
        b.wreg       = 5'($urandom_range(0, 31));
        b.alu_result = alu;
        b.mem_en     = mem_en;
        b.reg2       = reg2;
        b.load_type  = lt;
        b.store_type = st;
        b.csr_wdata  = $urandom();
        b.csr_flag   = 3'($urandom_range(0, 7));
        b.csr_waddr  = 12'($urandom_range(0, 4095));
        b.csr_mcause = $urandom();
        b.ebreak     = 1'($urandom_range(0, 1));
        b.fencei     = 1'($urandom_range(0, 1));
        return b;
    endfunction

    // Called at a negedge; returns just after the capturing posedge.
    task automatic send(input string tag, input es_bus_t b);
        check({tag, " allowin"}, lsu_allowin_o, 1);
        es_to_ms_bus      = b;
        es_to_lsu_valid_i = 1'b1;
        @(posedge clock);
        #1 es_to_lsu_valid_i = 1'b0;
    endtask

    task automatic check_output(input string tag, input es_bus_t b, input logic [31:0] exp_final);
        bit csr_en;
        csr_en = (b.csr_flag == 3'd1) || (b.csr_flag == 3'd2) || (b.csr_flag == 3'd3);
        check({tag, " wb_valid"}, ms_to_wb_valid_o, 1);
        check({tag, " final"}, ms_to_wb_bus[112:81], exp_final);
        check({tag, " wb_hdr"}, ms_to_wb_bus[150:113], {b.pc, b.wd, b.wreg});
        check({tag, " wb_csr"}, ms_to_wb_bus[80:0], {b.csr_wdata, b.csr_flag, b.csr_waddr,
                                                     b.csr_mcause, b.ebreak, b.fencei});
        check({tag, " fwd_ctl"}, ms_to_ds_forward_bus[86:85], {1'b0, b.wd && (b.wreg != 0)});
        check({tag, " fwd_data"}, ms_to_ds_forward_bus[84:0],
              {b.wreg, exp_final, csr_en, b.csr_waddr, b.csr_wdata, b.csr_flag});
        check({tag, " req_idle"}, data_req_o, 0);
    endtask

    // Runs one instruction from capture to the cycle its output is valid (ends at that negedge).
    task automatic run_instr(input string tag, input es_bus_t b, input int gnt_wait, input int rv_wait,
                             input logic [31:0] rdata);
        int lt;
        int st;
        bit ld;
        bit mem;
        logic [31:0] exp_final;
        lt  = b.load_type;
        st  = b.store_type;
        ld  = b.mem_en && lt >= 1 && lt <= 5;
        mem = ld || (b.mem_en && st != 0);
        exp_final = ld ? model_load(lt, b.alu_result, rdata) : b.alu_result;
        send(tag, b);
        if (mem) begin
            for (int i = 0; i <= gnt_wait; i++) begin
                @(negedge clock);
                check({tag, " req"}, data_req_o, 1);
                check({tag, " addr"}, data_addr_o, b.alu_result);
                check({tag, " we"}, data_we_o, !ld);
                check({tag, " wstrb"}, data_wstrb_o, ld ? 4'd0 : model_wstrb(st, b.alu_result));
                if (!ld) check({tag, " wdata"}, data_wdata_o, model_wdata(st, b.reg2));
                check({tag, " early_valid"}, ms_to_wb_valid_o, 0);
                check({tag, " stall"}, ms_to_ds_forward_bus[86], ld);
                if (i == gnt_wait) data_gnt_i = 1'b1;
                @(posedge clock);
                #1 data_gnt_i = 1'b0;
            end
            for (int i = 0; i <= rv_wait; i++) begin
                @(negedge clock);
                check({tag, " wait_req"}, data_req_o, 0);
                check({tag, " wait_valid"}, ms_to_wb_valid_o, 0);
                if (i == rv_wait) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rdata;
                end
                @(posedge clock);
                #1 data_rvalid_i = 1'b0;
                data_rdata_i = $urandom();
            end
        end
        @(negedge clock);
        check_output(tag, b, exp_final);
    endtask

    task automatic retire(input string tag);
        @(posedge clock);
        @(negedge clock);
        check({tag, " retired"}, ms_to_wb_valid_o, 0);
        check({tag, " allowin_after"}, lsu_allowin_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        es_bus_t b;
        es_to_ms_bus         = '0;
        es_to_lsu_valid_i    = 1'b0;
        wb_allowin_i         = 1'b1;
        fencei_flush_sign_i  = 1'b0;
        fencei_flush_valid_i = 1'b0;
        data_gnt_i           = 1'b0;
        data_rvalid_i        = 1'b0;
        data_rdata_i         = '0;
        reset                = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst req", data_req_o, 0);
        check("rst wb_valid", ms_to_wb_valid_o, 0);
        check("rst allowin", lsu_allowin_o, 1);
        check("rst wb_bus", ms_to_wb_bus, 0);
        check("rst fwd_bus", ms_to_ds_forward_bus, 0);

        // Non-memory op, one-cycle pass-through.
        b = mk_bus(32'h1234, 1'b0, LD_NONE, ST_NONE, $urandom());
        run_instr("add", b, 0, 0, 0);
        retire("add");

        // LB / LBU at the top byte lane: grant at +1, rvalid at +3.
        b = mk_bus(32'h8000_0003, 1'b1, LD_LB, ST_NONE, $urandom());
        run_instr("lb", b, 0, 1, 32'h80FF_FFFF);
        check("lb const", ms_to_wb_bus[112:81], 32'hFFFF_FF80);
        retire("lb");
        b = mk_bus(32'h8000_0003, 1'b1, LD_LBU, ST_NONE, $urandom());
        run_instr("lbu", b, 0, 1, 32'h80FF_FFFF);
        check("lbu const", ms_to_wb_bus[112:81], 32'h0000_0080);
        retire("lbu");

        // SH to the upper half.
        b = mk_bus(32'h2, 1'b1, LD_NONE, ST_SH, 32'h0000_ABCD);
        send("sh", b);
        @(negedge clock);
        check("sh wstrb", data_wstrb_o, 4'b1100);
        check("sh wdata", data_wdata_o, 32'hABCD_ABCD);
        check("sh we", data_we_o, 1);
        data_gnt_i = 1'b1;
        @(posedge clock);
        #1 data_gnt_i = 1'b0;
        @(negedge clock);
        check("sh no_valid", ms_to_wb_valid_o, 0);
        data_rvalid_i = 1'b1;
        @(posedge clock);
        #1 data_rvalid_i = 1'b0;
        @(negedge clock);
        check_output("sh", b, 32'h2);
        retire("sh");

        // Grant withheld five cycles on a pending load.
        b = mk_bus(32'h0000_1006, 1'b1, LD_LH, ST_NONE, $urandom());
        run_instr("lh_stall", b, 5, 0, 32'h8001_7FFE);
        retire("lh_stall");

        // Reserved load encoding behaves as a non-memory op.
        b = mk_bus(32'hCAFE_0001, 1'b1, 3'd6, ST_NONE, $urandom());
        run_instr("lt6", b, 0, 0, 0);
        retire("lt6");

        // Flush in WAIT: orphaned response is discarded, stage blocked until it arrives.
        b = mk_bus(32'h0000_0040, 1'b1, LD_LW, ST_NONE, $urandom());
        send("fl_wait", b);
        @(negedge clock);
        check("fl_wait req", data_req_o, 1);
        data_gnt_i = 1'b1;
        @(posedge clock);
        #1 data_gnt_i = 1'b0;
        @(negedge clock);
        fencei_flush_sign_i  = 1'b1;
        fencei_flush_valid_i = 1'b1;
        #1 check("fl_wait valid", ms_to_wb_valid_o, 0);
        @(posedge clock);
        #1 fencei_flush_sign_i  = 1'b0;
        fencei_flush_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("fl_wait allowin", lsu_allowin_o, 0);
            check("fl_wait out", ms_to_wb_valid_o, 0);
            check("fl_wait req_off", data_req_o, 0);
        end
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hDEAD_BEEF;
        @(posedge clock);
        #1 data_rvalid_i = 1'b0;
        @(negedge clock);
        check("fl_wait released", lsu_allowin_o, 1);
        check("fl_wait dropped", ms_to_wb_valid_o, 0);
        b = mk_bus(32'h0000_0044, 1'b1, LD_LW, ST_NONE, $urandom());
        run_instr("after_orphan", b, 1, 0, 32'h1357_9BDF);
        retire("after_orphan");

        // Flush in REQ before grant drops the request.
        b = mk_bus(32'h0000_0100, 1'b1, LD_NONE, ST_SW, $urandom());
        send("fl_req", b);
        @(negedge clock);
        check("fl_req req", data_req_o, 1);
        fencei_flush_sign_i  = 1'b1;
        fencei_flush_valid_i = 1'b1;
        @(posedge clock);
        #1 fencei_flush_sign_i  = 1'b0;
        fencei_flush_valid_i = 1'b0;
        @(negedge clock);
        check("fl_req dropped", data_req_o, 0);
        check("fl_req allowin", lsu_allowin_o, 1);
        check("fl_req valid", ms_to_wb_valid_o, 0);

        // Flush kills a ready output in the same cycle; sign alone does not.
        b = mk_bus(32'h0000_0555, 1'b0, LD_NONE, ST_NONE, $urandom());
        send("fl_out", b);
        @(negedge clock);
        check("fl_out before", ms_to_wb_valid_o, 1);
        fencei_flush_sign_i = 1'b1;
        #1 check("fl_out sign_only", ms_to_wb_valid_o, 1);
        fencei_flush_valid_i = 1'b1;
        #1 check("fl_out killed", ms_to_wb_valid_o, 0);
        @(posedge clock);
        #1 fencei_flush_sign_i  = 1'b0;
        fencei_flush_valid_i = 1'b0;
        @(negedge clock);
        check("fl_out gone", ms_to_wb_valid_o, 0);
        check("fl_out fwd", ms_to_ds_forward_bus[85], 0);

        // Back-pressure after a completed load.
        wb_allowin_i = 1'b0;
        b = mk_bus(32'h0000_0201, 1'b1, LD_LBU, ST_NONE, $urandom());
        run_instr("bp", b, 0, 0, 32'h0000_9900);
        repeat (3) begin
            @(negedge clock);
            check("bp valid", ms_to_wb_valid_o, 1);
            check("bp allowin", lsu_allowin_o, 0);
            check("bp no_req", data_req_o, 0);
            check("bp final", ms_to_wb_bus[112:81], 32'h0000_0099);
        end
        wb_allowin_i = 1'b1;
        retire("bp");

        // Reset in the middle of a transaction.
        b = mk_bus(32'h0000_0300, 1'b1, LD_LW, ST_NONE, $urandom());
        send("mid_rst", b);
        @(negedge clock);
        data_gnt_i = 1'b1;
        @(posedge clock);
        #1 data_gnt_i = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("mid_rst req", data_req_o, 0);
        check("mid_rst valid", ms_to_wb_valid_o, 0);
        check("mid_rst allowin", lsu_allowin_o, 1);
        check("mid_rst wb_bus", ms_to_wb_bus, 0);
        check("mid_rst fwd", ms_to_ds_forward_bus, 0);

        // Randomized mix of non-memory ops, loads and stores.
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 2);
            addr = $urandom();
            case (kind)
                0: b = mk_bus(addr, 1'($urandom_range(0, 1)), 3'($urandom_range(6, 7)) & {3{1'($urandom_range(0, 1))}},
                              ST_NONE, $urandom());
                1: b = mk_bus(addr, 1'b1, 3'($urandom_range(1, 5)), ST_NONE, $urandom());
                default: b = mk_bus(addr, 1'b1, LD_NONE, 2'($urandom_range(1, 3)), $urandom());
            endcase
            run_instr("rand", b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom());
            retire("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_mem_stage.md
# ysyx_23060025_mem_stage

Memory-access pipeline stage between the execute stage and write-back. Latches the execute-to-memory bus, issues at most one load/store per instruction on a request/grant/response data port, and sign/zero-extends load data. Produces the memory-to-write-back bus and a forward bus to decode. Non-memory instructions pass through in one cycle.

## Interface
- `ES_TO_MS_DATA_BUS`, default 189: input bus width, with fields MSB→LSB:
  - pc[32], wd[1], wreg[5], alu_result[32], mem_en[1], reg2[32], load_type[3], store_type[2]
  - csr_wdata[32], csr_flag[3], csr_waddr[12], csr_mcause[32], ebreak[1], fencei[1]
- `MS_TO_WB_DATA_BUS`, default 151: output bus, with fields pc, wd, wreg, final_result[32], csr_wdata, csr_flag, csr_waddr, csr_mcause, ebreak, fencei.
- `MS_TO_DS_FORWARD_BUS`, default 87: fields {dep_need_stall, forward_enable, wreg, final_result, csr_forward_enable, csr_waddr, csr_wdata, csr_flag}.
- Ports:
  - clock  in  1  sole clock
  - reset  in  1  synchronous, active-high
  - es_to_ms_bus  in  189  execute payload
  - es_to_lsu_valid_i  in  1  upstream valid
  - lsu_allowin_o  out  1  stage can accept
  - ms_to_wb_bus  out  151  write-back payload
  - ms_to_wb_valid_o  out  1  downstream valid
  - wb_allowin_i  in  1  downstream can accept
  - ms_to_ds_forward_bus  out  87  forward/stall info
  - fencei_flush_sign_i, fencei_flush_valid_i  in  1 each  flush when both are high
  - data_req_o  out  1  request valid
  - data_we_o  out  1  1 = store
  - data_addr_o  out  32  byte address (alu_result)
  - data_wstrb_o  out  4  byte enables
  - data_wdata_o  out  32  lane-replicated store data
  - data_gnt_i  in  1  request accepted
  - data_rvalid_i  in  1  response (load data or store ack)
  - data_rdata_i  in  32  aligned word

## Operation
- Bus register loads when es_to_lsu_valid_i & lsu_allowin_o; ms_valid loads es_to_lsu_valid_i whenever lsu_allowin_o.
- load_type encoding: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6–7 are treated as none. store_type encoding: 0 none, 1 SB, 2 SH, 3 SW.
- FSM states:
  - IDLE: a valid memory op enters → REQ.
  - REQ: data_req_o=1; on data_gnt_i → WAIT.
  - WAIT: on data_rvalid_i, capture data_rdata_i into a hold register, set done → IDLE.
- Non-memory op: ready_go=1 immediately. Memory op: ready_go = done. done clears when the instruction leaves.
- wstrb:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW: 4'b1111
  - data_wdata_o: SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, SW reg2.
- Load result: select byte addr[1:0] or half addr[1], then sign- or zero-extend. final_result is the load result for loads, otherwise alu_result. Misalignment is not checked; the address is forwarded as-is.
- Forward bus:
  - forward_enable = wd & wreg≠0 & ms_valid
  - dep_need_stall = ms_valid & load & ~done
  - csr_forward_enable = ms_valid & csr_flag∈{CSRRW,CSRRS,ECALL}
- Flush: ms_valid←0 and ms_to_wb_valid_o forced 0 in the same cycle.
  - Flush in REQ before grant: request dropped → IDLE.
  - Flush in WAIT: orphan flag set; the FSM stays in WAIT, discards the response, then → IDLE. lsu_allowin_o=0 while orphan is set.
- lsu_allowin_o = ~orphan & (~ms_valid | ready_go & wb_allowin_i).
- ms_to_wb_valid_o = ms_valid & ready_go & ~flush.

## Timing
- Reset values:
  - FSM=IDLE; ms_valid, done, orphan, and the bus register = 0.
  - Hence data_req_o=0, ms_to_wb_valid_o=0, lsu_allowin_o=1, and all buses 0.
- Non-memory latency: 1 cycle (valid the cycle after capture).
- Memory latency: capture → REQ next cycle; output valid the cycle after data_rvalid_i.
- data_rvalid_i never arrives in the same cycle as its grant.
- data_req_o and all data_* outputs are held stable until data_gnt_i.
- Reset mid-transaction abandons it; the memory side is reset in the same cycle.

## Configuration
- MS_PERF_CNT_EN defined: adds output ports perf_load_cnt_o, perf_store_cnt_o, perf_wait_cnt_o (32 bits each, reset 0, wrapping).
  - Load/store counters increment on each completed non-flushed access.
  - Wait counter increments each cycle in REQ or WAIT.
- Undefined: ports and counters are absent; function is otherwise identical.

## Structure
- Shared define file: the three bus widths, the load/store encodings, `CSR_CSRRW/CSRRS/ECALL`, and the FSM state constants.
- One sub-module: ysyx_23060025_load_ext (combinational lane select and extend).

## Test plan
- ADD with alu_result=0x1234, wb_allowin=1 → ms_to_wb_valid 1 cycle after capture, final_result=0x1234, no data_req.
- LB at addr 0x80000003, rdata=0x80FFFFFF, grant at +1, rvalid at +3 → final_result=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at addr 0x2, reg2=0xABCD → wstrb=4'b1100, wdata=0xABCDABCD, we=1; valid only after rvalid.
- Grant withheld 5 cycles → req/addr/wdata stable for all 5 cycles; dep_need_stall=1 for a pending load.
- Flush during WAIT → ms_to_wb_valid=0, lsu_allowin=0 until rvalid; response discarded; next instruction accepted afterwards.
- wb_allowin=0 after load done → data held, lsu_allowin=0, no second request issued.
